// File: rtl/shit_spawn_ctrl.sv
// shit_spawn_ctrl: producer side of the 8-slot dropping bus.
// Owns alive/X/Y for eight falling droppings; once per frame it advances
// every live slot, retires slots that fall past the bottom, and spawns new
// droppings at a pseudo-random X.
// Optional feature macro: SHIT_GRAVITY_EN (per-slot accelerating velocity).
module shit_spawn_ctrl #(
  parameter int unsigned SPAWN_PERIOD = 30,
  parameter int unsigned X_MIN        = 64,
  parameter int          TOP_Y        = 0,
  parameter int          BOTTOM_Y     = 479,
  parameter int          PARK_Y       = -64,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          startOfFrame,
  input  logic                          spawnEnable,
  input  logic [3:0]                    speed,
  input  logic [7:0]                    hitRequest,
  output logic signed [7:0][1:0][10:0]  shitCoordinates,
  output logic [7:0]                    shitsActive,
  output logic                          missPulse,
  output logic                          busy
);

  localparam int unsigned NSLOT = 8;
  localparam int unsigned CW    = 11;
  localparam int unsigned LW    = 16;
  localparam int unsigned SW    = 4;
  localparam int unsigned IW    = 3;
  localparam int unsigned FW    = 8;
  localparam int unsigned XRW   = 9;

  localparam logic signed [CW-1:0] TOP_C    = CW'(TOP_Y);
  localparam logic signed [CW-1:0] BOTTOM_C = CW'(BOTTOM_Y);
  localparam logic signed [CW-1:0] PARK_C   = CW'(PARK_Y);
  localparam logic signed [CW-1:0] XMIN_C   = CW'(X_MIN);
  localparam logic [FW-1:0]        WRAP_C   = FW'(SPAWN_PERIOD - 1);
  localparam logic [IW-1:0]        LAST_C   = IW'(NSLOT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    SPAWN = 2'd2
  } state_t;

  state_t                              state_q, state_nxt;
  logic [IW-1:0]                       idx_q, idx_nxt;
  logic [FW-1:0]                       frame_q, frame_nxt;
  logic                                armed_q, armed_nxt;
  logic                                miss_seen_q, miss_seen_nxt;
  logic [LW-1:0]                       lfsr_q, lfsr_nxt;
  logic [NSLOT-1:0]                    alive_nxt;
  logic signed [NSLOT-1:0][1:0][CW-1:0] coord_nxt;
  logic                                miss_nxt;
  logic                                busy_nxt;

  logic signed [CW-1:0]                cur_y;
  logic signed [CW-1:0]                new_y;
  logic [SW-1:0]                       step;
  logic                                any_dead;
  logic [IW-1:0]                       free_idx;
  logic [LW-1:0]                       lfsr_step;

`ifdef SHIT_GRAVITY_EN
  logic [NSLOT-1:0][SW-1:0]            vel_q, vel_nxt;
`endif

  // Lowest-index dead slot, used as the spawn target.
  always_comb begin
    any_dead = 1'b0;
    free_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!shitsActive[i]) begin
        any_dead = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Fall step for the slot currently being walked, and the next LFSR value.
  always_comb begin
`ifdef SHIT_GRAVITY_EN
    step = vel_q[idx_q];
`else
    step = speed;
`endif
    cur_y     = shitCoordinates[idx_q][1];
    new_y     = cur_y + $signed({{(CW - SW){1'b0}}, step});
    lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LW-1:1]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state, slot update and spawn decision.
  always_comb begin
    state_nxt     = state_q;
    idx_nxt       = idx_q;
    frame_nxt     = frame_q;
    armed_nxt     = armed_q;
    miss_seen_nxt = miss_seen_q;
    lfsr_nxt      = lfsr_q;
    alive_nxt     = shitsActive;
    coord_nxt     = shitCoordinates;
    miss_nxt      = 1'b0;
`ifdef SHIT_GRAVITY_EN
    vel_nxt       = vel_q;
`endif

    case (state_q)
      IDLE: begin
        if (startOfFrame) begin
          state_nxt     = MOVE;
          idx_nxt       = '0;
          miss_seen_nxt = 1'b0;
          if (frame_q == WRAP_C) begin
            frame_nxt = '0;
            armed_nxt = 1'b1;
          end else begin
            frame_nxt = frame_q + FW'(1);
          end
        end
      end

      MOVE: begin
        if (shitsActive[idx_q]) begin
          if (new_y > BOTTOM_C) begin
            alive_nxt[idx_q]    = 1'b0;
            coord_nxt[idx_q][1] = PARK_C;
            // Only the first retire of a frame produces a pulse; a
            // simultaneous hit takes priority and is not a miss.
            if (!hitRequest[idx_q] && !miss_seen_q) begin
              miss_nxt      = 1'b1;
              miss_seen_nxt = 1'b1;
            end
          end else begin
            coord_nxt[idx_q][1] = new_y;
`ifdef SHIT_GRAVITY_EN
            if (vel_q[idx_q] != {SW{1'b1}}) begin
              vel_nxt[idx_q] = vel_q[idx_q] + SW'(1);
            end
`endif
          end
        end
        if (idx_q == LAST_C) begin
          state_nxt = SPAWN;
        end else begin
          idx_nxt = idx_q + IW'(1);
        end
      end

      SPAWN: begin
        lfsr_nxt  = lfsr_step;
        armed_nxt = 1'b0;
        state_nxt = IDLE;
        if (armed_q && spawnEnable && any_dead && !hitRequest[free_idx]) begin
          alive_nxt[free_idx]    = 1'b1;
          coord_nxt[free_idx][0] = XMIN_C + $signed({{(CW - XRW){1'b0}}, lfsr_q[XRW-1:0]});
          coord_nxt[free_idx][1] = TOP_C;
`ifdef SHIT_GRAVITY_EN
          vel_nxt[free_idx]      = speed;
`endif
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Collision kills override whatever the FSM wrote this cycle.
    for (int i = 0; i < NSLOT; i++) begin
      if (hitRequest[i]) begin
        alive_nxt[i]    = 1'b0;
        coord_nxt[i][1] = PARK_C;
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // Slot state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      frame_q     <= '0;
      armed_q     <= 1'b0;
      miss_seen_q <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      shitsActive <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        shitCoordinates[i][0] <= '0;
        shitCoordinates[i][1] <= PARK_C;
      end
      missPulse   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      idx_q           <= idx_nxt;
      frame_q         <= frame_nxt;
      armed_q         <= armed_nxt;
      miss_seen_q     <= miss_seen_nxt;
      lfsr_q          <= lfsr_nxt;
      shitsActive     <= alive_nxt;
      shitCoordinates <= coord_nxt;
      missPulse       <= miss_nxt;
      busy            <= busy_nxt;
    end
  end

`ifdef SHIT_GRAVITY_EN
  // Per-slot velocity registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vel_q <= '0;
    end else begin
      vel_q <= vel_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_shit_spawn_ctrl.sv
// tb_shit_spawn_ctrl: directed, table-driven bench for shit_spawn_ctrl.
module tb_shit_spawn_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic                         clk;
  logic                         reset;
  logic                         startOfFrame;
  logic                         spawnEnable;
  logic [3:0]                   speed;
  logic [7:0]                   hitRequest;
  logic signed [7:0][1:0][10:0] coords;
  logic [7:0]                   shitsActive;
  logic                         missPulse;
  logic                         busy;

  int n_chk  = 0;
  int n_fail = 0;
  int miss_cnt = 0;

  shit_spawn_ctrl #(.SPAWN_PERIOD(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .spawnEnable     (spawnEnable),
    .speed           (speed),
    .hitRequest      (hitRequest),
    .shitCoordinates (coords),
    .shitsActive     (shitsActive),
    .missPulse       (missPulse),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with missPulse high, sampled away from the active edge.
  always @(negedge clk) if (missPulse === 1'b1) miss_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       en;
    logic [3:0] spd;
    logic [7:0] exp_active;
    integer     exp_y0;
    integer     exp_y1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input integer act, input integer exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic integer y_of(input int i);
    logic signed [10:0] v;
    v = coords[i][1];
    return v;
  endfunction

  function automatic integer x_of(input int i);
    logic signed [10:0] v;
    v = coords[i][0];
    return v;
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (b << 15);
  endfunction

  // Spawn X for a spawn whose SPAWN state is reached after k earlier LFSR steps.
  function automatic integer x_after(input int k);
    logic [15:0] s;
    integer v;
    s = SEED;
    for (int j = 0; j < k; j++) s = lfsr_adv(s);
    v = 64 + integer'(s & 16'h01FF);
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    startOfFrame = 1'b0;
    hitRequest = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One frame: sof pulse, optional hit mask at cycle hit_at, optional
  // extra sof at cycle sof_at; waits (bounded) for busy to fall.
  task automatic run_frame(input logic en, input logic [3:0] spd,
                           input logic [7:0] hit_mask, input int hit_at,
                           input int sof_at);
    int lat;
    lat = 0;
    spawnEnable = en;
    speed = spd;
    startOfFrame = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      startOfFrame = (n == sof_at);
      hitRequest = (n == hit_at) ? hit_mask : 8'h00;
      if (n > 1 && !busy) begin
        lat = n;
        break;
      end
    end
    startOfFrame = 1'b0;
    hitRequest = '0;
    chk("frame_latency", lat, 10);
  endtask

  initial begin
    int m0;
    reset = 1'b1;
    startOfFrame = 1'b0;
    spawnEnable = 1'b0;
    speed = '0;
    hitRequest = '0;

    vecs[0] = '{1'b1, 4'd4, 8'h00, -64, -64};
    vecs[1] = '{1'b1, 4'd4, 8'h01,   0, -64};
    vecs[2] = '{1'b1, 4'd4, 8'h01,   4, -64};
    vecs[3] = '{1'b1, 4'd4, 8'h03,   8,   0};
    vecs[4] = '{1'b1, 4'd4, 8'h03,  12,   4};
    vecs[5] = '{1'b1, 4'd4, 8'h07,  16,   8};

    // Reset state.
    do_reset();
    chk("rst_active", shitsActive, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miss", missPulse, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_y%0d", i), y_of(i), -64);
      chk($sformatf("rst_x%0d", i), x_of(i), 0);
    end

    // Spawning disabled: nothing appears, no misses.
    m0 = miss_cnt;
    repeat (3) run_frame(1'b0, 4'd4, 8'h00, 0, 0);
    chk("nospawn_active", shitsActive, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("nospawn_y%0d", i), y_of(i), -64);
    chk("nospawn_miss", miss_cnt - m0, 0);

    // Table of frames from a fresh reset.
    do_reset();
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].en, vecs[v].spd, 8'h00, 0, 0);
      chk($sformatf("vec%0d_active", v), shitsActive, integer'(vecs[v].exp_active));
      chk($sformatf("vec%0d_y0", v), y_of(0), vecs[v].exp_y0);
      chk($sformatf("vec%0d_y1", v), y_of(1), vecs[v].exp_y1);
    end
    chk("spawn_x0", x_of(0), 176);
    chk("spawn_x1", x_of(1), 476);
    chk("spawn_x2", x_of(2), x_after(5));
    chk("spawn_y2", y_of(2), 0);

    // Hit on slot 0 in the cycle MOVE updates it.
    m0 = miss_cnt;
    run_frame(1'b0, 4'd4, 8'h01, 1, 0);
    chk("hit_active", shitsActive, 8'h06);
    chk("hit_y0", y_of(0), -64);
    chk("hit_y1", y_of(1), 12);
    chk("hit_y2", y_of(2), 4);
    chk("hit_miss", miss_cnt - m0, 0);

    // Drive slot 1 to Y=477, then fall past the bottom.
    repeat (31) run_frame(1'b0, 4'd15, 8'h00, 0, 0);
    chk("pre_miss_y1", y_of(1), 477);
    chk("pre_miss_y2", y_of(2), 469);
    m0 = miss_cnt;
    run_frame(1'b0, 4'd4, 8'h00, 0, 0);
    chk("miss_active", shitsActive, 8'h04);
    chk("miss_y1", y_of(1), -64);
    chk("miss_x1", x_of(1), 476);
    chk("miss_y2", y_of(2), 473);
    chk("miss_pulses", miss_cnt - m0, 1);

    // Extra startOfFrame during MOVE is dropped and not counted.
    do_reset();
    run_frame(1'b1, 4'd0, 8'h00, 0, 3);
    @(posedge clk);
    #1;
    chk("skip_busy_idle", busy, 0);
    chk("skip_active_f1", shitsActive, 0);
    run_frame(1'b1, 4'd0, 8'h00, 0, 0);
    chk("skip_active_f2", shitsActive, 8'h01);

    // Fill all eight slots, then an armed spawn with no free slot.
    for (int f = 3; f <= 18; f++) run_frame(1'b1, 4'd0, 8'h00, 0, 0);
    chk("full_active", shitsActive, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("full_x%0d", k), x_of(k), x_after(2 * k + 1));
      chk($sformatf("full_y%0d", k), y_of(k), 0);
    end

    // Free slot 3 while idle; the next spawn shows the LFSR kept stepping.
    hitRequest = 8'h08;
    @(posedge clk);
    #1;
    hitRequest = 8'h00;
    chk("kill3_active", shitsActive, 8'hF7);
    chk("kill3_y", y_of(3), -64);
    run_frame(1'b1, 4'd0, 8'h00, 0, 0);
    run_frame(1'b1, 4'd0, 8'h00, 0, 0);
    chk("respawn_active", shitsActive, 8'hFF);
    chk("respawn_x3", x_of(3), x_after(19));
    chk("respawn_y3", y_of(3), 0);

    // Reset in the middle of an update.
    spawnEnable = 1'b1;
    startOfFrame = 1'b1;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_active", shitsActive, 0);
    chk("mid_y3", y_of(3), -64);
    chk("mid_x3", x_of(3), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("mid_stay_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
